// File: rtl/mod_reg16_16to4.sv
// mod_reg16_16to4 -- output-side block serializer for the AES256 core.
//
// Captures a whole 16-byte cipher state in one cycle and presents it as four
// 32-bit words under a valid/pop handshake. Two block slots work as a
// ping-pong pair, so the core can deposit its next result while the previous
// one is still draining.
//
// Ports:
//   clk        clock, rising edge
//   resetn     asynchronous, active-high reset (1 = clear all state)
//   wr_en      load request; i is captured when wr_en=1 and reg_full=0
//   i          input block, byte k = i[k]
//   rd_en      pop request; consumes the current word when o_valid=1
//   o          current word w = {i[4w+3], i[4w+2], i[4w+1], i[4w]} of head block
//   o_valid    o holds a valid word
//   o_last     o is the final word of its block
//   reg_full   both slots occupied; loads are dropped
//   reg_empty  no slots occupied
module mod_reg16_16to4 #(
  parameter int N     = 16,
  parameter int WB    = 4,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [N-1:0][7:0]   i,
  input  logic                rd_en,
  output logic [8*WB-1:0]     o,
  output logic                o_valid,
  output logic                o_last,
  output logic                reg_full,
  output logic                reg_empty
);

  localparam int NW = N / WB;
  localparam int WW = 8 * WB;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  // Block storage; contents are never reset, only the bookkeeping is.
  logic [N-1:0][7:0] slot_mem [0:DEPTH-1];

  logic          wr_ptr_reg,   wr_ptr_next;
  logic          rd_ptr_reg,   rd_ptr_next;
  logic [1:0]    count_reg,    count_next;
  logic [IW-1:0] word_idx_reg, word_idx_next;

  logic load;
  logic pop;
  logic pop_last;

  // Flags decode straight from the registered occupancy.
  assign reg_full  = (count_reg == 2'(DEPTH));
  assign reg_empty = (count_reg == 2'd0);
  assign o_valid   = !reg_empty;
  assign o_last    = o_valid && (word_idx_reg == IW'(NW - 1));

  // Handshake qualification: loads only into a free slot, pops only of a
  // valid word. Both use the pre-edge flags, so a full register rejects a
  // load even if the final pop of the head block happens in the same cycle.
  assign load     = wr_en && !reg_full;
  assign pop      = rd_en && o_valid;
  assign pop_last = pop && (word_idx_reg == IW'(NW - 1));

  // Word selection from the head block.
  logic [N-1:0][7:0] head_blk;
  logic [WW-1:0]     word_vec [0:NW-1];

  assign head_blk = slot_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_word
      assign word_vec[gi] = head_blk[gi*WB +: WB];
    end
  endgenerate

  // Forced to zero when nothing is held, which also covers the reset case.
  assign o = o_valid ? word_vec[word_idx_reg] : '0;

  always_comb begin
    count_next    = count_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    word_idx_next = word_idx_reg;

    // Load and final pop together leave occupancy unchanged.
    case ({load, pop_last})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase

    if (load) begin
      wr_ptr_next = ~wr_ptr_reg;
    end

    if (pop_last) begin
      rd_ptr_next   = ~rd_ptr_reg;
      word_idx_next = '0;
    end else if (pop) begin
      word_idx_next = word_idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      word_idx_reg <= '0;
    end else begin
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      word_idx_reg <= word_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      slot_mem[wr_ptr_reg] <= i;
    end
  end

endmodule

// File: doc/mod_reg16_16to4.md
Name: mod_reg16_16to4

Overview:
- Output-side serializer for the AES256 core. Sits directly downstream of the cipher datapath, mirroring the 4x32-bit input collector on the input side.
- Accepts a complete 128-bit state (16 bytes) in one cycle and presents it to the bus as four 32-bit words under a valid/pop handshake.
- Two-block ping-pong storage lets the core deposit the next result while the previous one is still draining.

Parameters:
- N, 16, bytes per block.
- WB, 4, bytes per output word. Words per block NW = N/WB = 4. N must be a multiple of WB.
- DEPTH, 2, block slots. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-high (resetn=1 clears all state immediately).
- wr_en  in  1  load request; block on i is captured when wr_en=1 and reg_full=0.
- i  in  [(N-1):0][7:0]  128-bit block; byte k = i[k].
- rd_en  in  1  pop request; consumes current word when rd_en=1 and o_valid=1.
- o  out  [(8*WB-1):0]  current word; word w = {i[4w+3], i[4w+2], i[4w+1], i[4w]} of the head block.
- o_valid  out  1  o holds a valid word (count>0).
- o_last  out  1  o is word NW-1 of its block (qualified by o_valid).
- reg_full  out  1  both slots occupied; loads ignored.
- reg_empty  out  1  no slots occupied.

Behaviour:
- State:
  - slot[0..1] (128 bits each).
  - wr_ptr, rd_ptr (1 bit each).
  - count (0..2).
  - word_idx (0..NW-1).
- Reset (resetn=1, async):
  - count=0, wr_ptr=0, rd_ptr=0, word_idx=0.
  - Outputs: o_valid=0, o_last=0, reg_full=0, reg_empty=1.
  - o=0 while reset is asserted; slot contents need not be cleared.
- Load: wr_en & !reg_full captures i into slot[wr_ptr], toggles wr_ptr, count+1.
  - Load when reg_full is silently dropped; no state change.
- Output selection: o, o_valid, o_last and the flags are combinational decodes of registered state.
  - o = word word_idx of slot[rd_ptr].
- Latency: a block loaded at edge t has word 0 on o with o_valid=1 after edge t (visible in cycle t+1).
- Pop: rd_en & o_valid increments word_idx.
  - On pop with word_idx=NW-1: word_idx->0, rd_ptr toggles, count-1.
  - rd_en while o_valid=0 is ignored.
- Simultaneous load and final pop in the same cycle:
  - If count=1: both take effect, count stays 1. Next block's word 0 appears next cycle with no bubble.
  - If count=2: the load is rejected (reg_full=1 that cycle); the pop proceeds and count becomes 1.
- Non-final pop with simultaneous load: both take effect independently.
- Throughput: one word per cycle with rd_en held high. Sustained 4 cycles per block with no gaps between blocks.
- Reset mid-drain: immediately discards all blocks and the partial word position. After release, the first load starts at word 0.
- reg_full = (count==2); reg_empty = (count==0).
- No other outputs change on ignored requests.

Test Plan:
- Reset check:
  - Stimulus: assert resetn mid-cycle.
  - Required response: o_valid=0, reg_empty=1, reg_full=0, o=0 without waiting for a clock edge.
- Single block drain:
  - Stimulus: load i=0x30303030_22222222_11221122_00f000f0, then hold rd_en.
  - Required response: o=0x00f000f0, 0x11221122, 0x22222222, 0x30303030 on consecutive cycles; o_last=1 only on 0x30303030; reg_empty=1 afterwards.
- Fill to full:
  - Stimulus: load block A, then block B with no pops, then attempt block C.
  - Required response: reg_full=1 after B; C is dropped; draining yields A's 4 words then B's 4 words and never C.
- Back-to-back:
  - Stimulus: count=1, load block B in the same cycle as the pop of A word 3.
  - Required response: next cycle o=B word 0, o_valid=1, count=1; no bubble.
- Pop gating:
  - Stimulus: rd_en=1 while empty, then load A.
  - Required response: the first o is A word 0, because the empty-state pops were ignored.
- Reset mid-drain:
  - Stimulus: after popping 2 words of A, assert resetn, then load D=0x0000000D_0000000C_0000000B_0000000A.
  - Required response: first o=0x0000000A with o_last=0.
